instruction_fetch_stage: RTL

//   IF stage of the pipelined RV64 core: owns the PC register, drives the byte address into the

---
 rtl/instruction_fetch_stage.sv | 132 +++++++++++++
 1 files changed

// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_stage
// Description : IF stage of the pipelined RV64 core. Owns the PC, presents it
//               to the combinational instruction memory and captures
//               {PC, Instruction} into the IF/ID register. Supports hazard
//               stalls, taken-branch redirect with flush, and a clean halt
//               once the PC walks past the end of instruction memory.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
    parameter logic [63:0] PC_RESET   = 64'd0,
    parameter int          IMEM_BYTES = 152,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    output logic [63:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid,
    output logic        halted
);

    localparam logic [0:0]  S_RUN     = 1'b0;
    localparam logic [0:0]  S_HALT    = 1'b1;
    localparam logic [63:0] c_last_pc = 64'(IMEM_BYTES - 4);

    logic [0:0]  r_state;
    logic [0:0]  w_next_state;
    logic [63:0] r_pc;
    logic [63:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;

    logic [63:0] w_target_aligned;
    logic        w_target_in_range;
    logic        w_pc_out_of_range;
    logic        w_load_target;
    logic        w_capture;
    logic        w_bubble;
    logic        w_halted;

    // Redirect targets are forced to word alignment before any range check.
    assign w_target_aligned  = branch_target & ~64'd3;
    assign w_target_in_range = (w_target_aligned <= c_last_pc);
    assign w_pc_out_of_range = (r_pc > c_last_pc);

    // State register: reset always wins, no partial update on that edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control: branch > stall > out-of-range > normal.
    always_comb begin
        w_next_state  = r_state;
        w_load_target = 1'b0;
        w_capture     = 1'b0;
        w_bubble      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (branch_taken) begin
                    w_load_target = 1'b1;
                    w_bubble      = 1'b1;
                end else if (stall) begin
                    w_next_state = S_RUN;
                end else if (w_pc_out_of_range) begin
                    w_bubble     = 1'b1;
                    w_next_state = S_HALT;
                end else begin
                    w_capture = 1'b1;
                end
            end
            S_HALT: begin
                // A branch still in EX may restart fetch; stall has no effect here.
                if (branch_taken) begin
                    w_load_target = 1'b1;
                    w_bubble      = 1'b1;
                    w_next_state  = w_target_in_range ? S_RUN : S_HALT;
                end
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // Output decode: halted comes straight from the state flop.
    always_comb begin
        w_halted = (r_state == S_HALT);
    end

    // PC and IF/ID register updates driven by the control decode above.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= PC_RESET;
            r_if_id_pc    <= 64'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (w_load_target) begin
            r_pc          <= w_target_aligned;
            r_if_id_pc    <= 64'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (w_bubble) begin
            r_if_id_pc    <= 64'd0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (w_capture) begin
            r_pc          <= r_pc + 64'd4;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= Instruction;
            r_if_id_valid <= 1'b1;
        end
    end

    assign Inst_Address      = r_pc;
    assign IF_ID_PC          = r_if_id_pc;
    assign IF_ID_Instruction = r_if_id_instr;
    assign IF_ID_Valid       = r_if_id_valid;
    assign halted            = w_halted;

endmodule
`default_nettype wire
